// File: rtl/obstacle_pool.sv
// Multi-slot obstacle engine for Dino Run: spawns, scrolls, retires and renders up to NumSlots obstacles.
// Optional feature macro OBSTACLE_BIRD_EN enables bird spawns and the wing-flap animation.
module obstacle_pool #(
   parameter int NumSlots    = 4,
   parameter int ScreenWidth = 640,
   parameter int GroundY     = 400,
   parameter int MinGap      = 160
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                next_frame_i,
   input  logic                spawn_i,
   input  logic [7:0]          rand_i,
   input  logic [3:0]          speed_i,
   input  logic [9:0]          pixel_x_i,
   input  logic [9:0]          pixel_y_i,
   output logic                pixel_o,
   output logic [NumSlots-1:0] active_o,
   output logic                spawned_o,
   output logic                dropped_o,
   output logic                passed_o
);

   localparam int          IdxW     = (NumSlots > 1) ? $clog2(NumSlots) : 1;
   localparam logic [10:0] SpawnX   = 11'(ScreenWidth);
   localparam logic [10:0] GapLimit = 11'(ScreenWidth - MinGap);
   localparam logic [10:0] Ground   = 11'(GroundY);

   logic [NumSlots-1:0] active_q;
   logic [10:0]         x_q    [NumSlots];
   logic [1:0]          kind_q [NumSlots];
   logic [1:0]          h_q    [NumSlots];

   logic                spawned_q, dropped_q, passed_q, pixel_q;
   logic [10:0]         speed_x;
   logic [NumSlots-1:0] retire;
   logic                free_any, gap_ok, spawn_ok;
   logic [IdxW-1:0]     free_idx;
   logic [1:0]          spawn_kind;
   logic                unused_rand;

   assign speed_x     = {7'd0, speed_i};
   assign unused_rand = ^rand_i[7:4];

   // Scan downwards so the lowest-index free slot is the one left in free_idx.
   always_comb begin
      free_any = 1'b0;
      gap_ok   = 1'b1;
      free_idx = '0;
      retire   = '0;
      for (int i = NumSlots - 1; i >= 0; i--) begin
         if (!active_q[i]) begin
            free_any = 1'b1;
            free_idx = IdxW'(i);
         end
         if (active_q[i] && (x_q[i] > GapLimit)) gap_ok = 1'b0;
         retire[i] = active_q[i] && (x_q[i] < speed_x);
      end
   end

   assign spawn_ok = spawn_i && free_any && gap_ok;

`ifdef OBSTACLE_BIRD_EN
   logic [2:0] frame_cnt_q;
   logic       flap_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frame_cnt_q <= 3'd0;
         flap_q      <= 1'b0;
      end else if (next_frame_i) begin
         frame_cnt_q <= frame_cnt_q + 3'd1;
         if (frame_cnt_q == 3'd7) flap_q <= ~flap_q;
      end
   end

   assign spawn_kind = rand_i[1:0];
`else
   assign spawn_kind = (rand_i[1:0] == 2'd3) ? 2'd0 : rand_i[1:0];
`endif

   // Free slots are picked from pre-update state, so a slot retired this frame is never reloaded now.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         active_q  <= '0;
         spawned_q <= 1'b0;
         dropped_q <= 1'b0;
         passed_q  <= 1'b0;
         for (int i = 0; i < NumSlots; i++) begin
            x_q[i]    <= 11'd0;
            kind_q[i] <= 2'd0;
            h_q[i]    <= 2'd0;
         end
      end else begin
         spawned_q <= 1'b0;
         dropped_q <= 1'b0;
         passed_q  <= 1'b0;
         if (next_frame_i) begin
            passed_q <= |retire;
            for (int i = 0; i < NumSlots; i++) begin
               if (retire[i]) active_q[i] <= 1'b0;
               else if (active_q[i]) x_q[i] <= x_q[i] - speed_x;
            end
            if (spawn_ok) begin
               active_q[free_idx] <= 1'b1;
               x_q[free_idx]      <= SpawnX;
               kind_q[free_idx]   <= spawn_kind;
               h_q[free_idx]      <= rand_i[3:2];
               spawned_q          <= 1'b1;
            end else if (spawn_i) begin
               dropped_q <= 1'b1;
            end
         end
      end
   end

   logic [10:0] px, py, w_c, hgt_c, bot_c, top_c;
   logic        hit;

   assign px = {1'b0, pixel_x_i};
   assign py = {1'b0, pixel_y_i};

   always_comb begin
      hit   = 1'b0;
      w_c   = 11'd0;
      hgt_c = 11'd0;
      bot_c = Ground;
      top_c = Ground;
      for (int i = 0; i < NumSlots; i++) begin
         bot_c = Ground;
         case (kind_q[i])
            2'd0:    begin w_c = 11'd16; hgt_c = 11'd32; end
            2'd1:    begin w_c = 11'd24; hgt_c = 11'd48; end
            2'd2:    begin w_c = 11'd40; hgt_c = 11'd32; end
            default: begin
               w_c   = 11'd32;
               hgt_c = 11'd16;
               case (h_q[i])
                  2'd0:    bot_c = Ground;
                  2'd1:    bot_c = Ground - 11'd24;
                  default: bot_c = Ground - 11'd48;
               endcase
            end
         endcase
`ifdef OBSTACLE_BIRD_EN
         // Wings-down frame: the top four sprite rows are blank.
         if ((kind_q[i] == 2'd3) && flap_q) hgt_c = 11'd12;
`endif
         top_c = bot_c - hgt_c;
         if (active_q[i] && (px >= x_q[i]) && (px < x_q[i] + w_c) &&
             (py >= top_c) && (py < bot_c)) hit = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) pixel_q <= 1'b0;
      else       pixel_q <= hit;
   end

   assign pixel_o   = pixel_q;
   assign active_o  = active_q;
   assign spawned_o = spawned_q;
   assign dropped_o = dropped_q;
   assign passed_o  = passed_q;

endmodule

// File: tb/tb_obstacle_pool.sv
// Self-checking bench for obstacle_pool: reference slot model feeds expected-result queues.
module tb_obstacle_pool;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       next_frame_i = 1'b0;
   logic       spawn_i = 1'b0;
   logic [7:0] rand_i = 8'd0;
   logic [3:0] speed_i = 4'd0;
   logic [9:0] pixel_x_i = 10'd0;
   logic [9:0] pixel_y_i = 10'd0;
   logic       pixel_o;
   logic [3:0] active_o;
   logic       spawned_o, dropped_o, passed_o;

   obstacle_pool dut (
      .clk_i(clk_i), .rst_i(rst_i), .next_frame_i(next_frame_i), .spawn_i(spawn_i),
      .rand_i(rand_i), .speed_i(speed_i), .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i),
      .pixel_o(pixel_o), .active_o(active_o), .spawned_o(spawned_o),
      .dropped_o(dropped_o), .passed_o(passed_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0] exp_q[$];
   logic       pix_q[$];

   // Reference model of the slot array
   logic [3:0] m_act;
   int         m_x[4];
   logic [1:0] m_kind[4];
   logic [1:0] m_h[4];
   int         m_cnt;
   logic       m_flap;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_act = 4'd0;
      m_cnt = 0;
      m_flap = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_x[i] = 0;
         m_kind[i] = 2'd0;
         m_h[i] = 2'd0;
      end
   endtask

   function automatic logic model_pix(input int px, input int py);
      logic hit;
      int   w, hg, bot;
      hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bot = 400;
         case (m_kind[i])
            2'd0: begin w = 16; hg = 32; end
            2'd1: begin w = 24; hg = 48; end
            2'd2: begin w = 40; hg = 32; end
            default: begin
               w = 32; hg = 16;
               bot = (m_h[i] == 2'd0) ? 400 : (m_h[i] == 2'd1) ? 376 : 352;
`ifdef OBSTACLE_BIRD_EN
               if (m_flap) hg = 12;
`endif
            end
         endcase
         if (m_act[i] && px >= m_x[i] && px < m_x[i] + w && py >= bot - hg && py < bot)
            hit = 1'b1;
      end
      return hit;
   endfunction

   task automatic apply_reset();
      rst_i = 1'b1;
      next_frame_i = 1'b1;
      spawn_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      next_frame_i = 1'b0;
      spawn_i = 1'b0;
      model_reset();
      exp_q.push_back(7'd0);
      pix_q.push_back(1'b0);
      check("reset_state", {active_o, spawned_o, dropped_o, passed_o}, exp_q.pop_front());
      check("reset_pixel", pixel_o, pix_q.pop_front());
   endtask

   task automatic do_frame(input logic sp, input logic [7:0] rb, input logic [3:0] spd);
      logic [3:0] nxt;
      logic       acc, pas, gap;
      int         fidx, s;
      s = spd;
      nxt = m_act;
      pas = 1'b0;
      gap = 1'b1;
      fidx = -1;
      for (int i = 3; i >= 0; i--) begin
         if (!m_act[i]) fidx = i;
         if (m_act[i] && m_x[i] > 480) gap = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         if (m_act[i]) begin
            if (m_x[i] < s) begin
               nxt[i] = 1'b0;
               pas = 1'b1;
            end else begin
               m_x[i] = m_x[i] - s;
            end
         end
      end
      acc = sp && (fidx >= 0) && gap;
      if (acc) begin
         nxt[fidx] = 1'b1;
         m_x[fidx] = 640;
         m_kind[fidx] = rb[1:0];
`ifndef OBSTACLE_BIRD_EN
         if (rb[1:0] == 2'd3) m_kind[fidx] = 2'd0;
`endif
         m_h[fidx] = rb[3:2];
      end
      m_act = nxt;
      if (m_cnt == 7) m_flap = ~m_flap;
      m_cnt = (m_cnt + 1) % 8;
      exp_q.push_back({nxt, acc, sp && !acc, pas});
      exp_q.push_back({nxt, 3'b000});

      spawn_i = sp;
      rand_i = rb;
      speed_i = spd;
      next_frame_i = 1'b1;
      @(posedge clk_i);
      #1;
      next_frame_i = 1'b0;
      spawn_i = 1'b0;
      check("frame", {active_o, spawned_o, dropped_o, passed_o}, exp_q.pop_front());
      @(posedge clk_i);
      #1;
      check("frame_idle", {active_o, spawned_o, dropped_o, passed_o}, exp_q.pop_front());
   endtask

   task automatic probe(input int px, input int py);
      pix_q.push_back(model_pix(px, py));
      pixel_x_i = 10'(px);
      pixel_y_i = 10'(py);
      @(posedge clk_i);
      #1;
      check("pixel", pixel_o, pix_q.pop_front());
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk_i);
      #1;
      apply_reset();

      // First spawn accepted, second dropped by the spawn gap
      do_frame(1'b1, 8'h00, 4'd4);
      probe(640, 390);
      probe(655, 368);
      probe(656, 368);
      do_frame(1'b1, 8'h00, 4'd4);
      probe(636, 399);
      probe(651, 399);
      probe(652, 399);

      // Large cactus scrolled to x=596: top and right edges
      apply_reset();
      do_frame(1'b1, 8'h01, 4'd4);
      for (int i = 0; i < 11; i++) do_frame(1'b0, 8'h00, 4'd4);
      probe(600, 352);
      probe(600, 351);
      probe(619, 399);
      probe(620, 399);
      probe(595, 380);
      probe(600, 400);

      // Fill every slot, then one more request is dropped
      n = 0;
      while (m_act != 4'hF && n < 60) begin
         do_frame(1'b1, 8'($urandom_range(0, 255)), 4'd15);
         n++;
      end
      check("fill_reached", m_act, 4'hF);
      do_frame(1'b1, 8'h00, 4'd15);
      do_frame(1'b1, 8'h02, 4'd0);

      // Bring slot0 to x=3, retire it with a full pool, then respawn
      n = 0;
      while (m_act[0] && m_x[0] > 18 && n < 100) begin
         do_frame(1'b1, 8'($urandom_range(0, 255)), 4'd15);
         n++;
      end
      if (m_act[0] && m_x[0] > 3) do_frame(1'b0, 8'h00, 4'(m_x[0] - 3));
      do_frame(1'b1, 8'h00, 4'd4);
      n = 0;
      while (m_act != 4'hF && n < 20) begin
         do_frame(1'b1, 8'h00, 4'd4);
         n++;
      end
      check("respawn_reached", m_act, 4'hF);

      // Kind-3 request: bird with the macro, small cactus without
      apply_reset();
      do_frame(1'b1, 8'h0F, 4'd4);
      probe(641, 336);
      probe(641, 351);
      probe(641, 352);
      probe(641, 335);
      probe(641, 368);
      probe(641, 399);
      probe(655, 340);
      probe(656, 370);
      for (int i = 0; i < 8; i++) do_frame(1'b0, 8'h00, 4'd0);
      probe(641, 337);
      probe(641, 340);
      probe(641, 380);

      // Mid-frame reset, then randomised traffic
      apply_reset();
      for (int k = 0; k < 60; k++) begin
         int j, px;
         do_frame(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
         j = $urandom_range(0, 3);
         px = m_x[j] + $urandom_range(0, 44) - 2;
         if (px < 0) px = 0;
         if (px > 1023) px = 1023;
         probe(px, $urandom_range(330, 402));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/obstacle_pool.md
# obstacle_pool

Parametrised multi-slot obstacle engine for Dino Run, the successor to the single-instance cactus and bird blocks. It holds up to `NumSlots` concurrent obstacles of mixed kind and scrolls them left by a runtime speed once per frame. It enforces a minimum spawn gap and retires obstacles that leave the screen. It drives one merged 1-bit obstacle pixel to the renderer and per-slot status to the game controller.

## Interface
Parameters:
- `NumSlots`, 4, number of concurrent obstacle slots (1..8)
- `ScreenWidth`, 640, spawn x-coordinate and screen width in pixels
- `GroundY`, 400, y of the ground line; obstacle bottoms rest here
- `MinGap`, 160, minimum pixels between the rightmost obstacle's left edge and `ScreenWidth` before a new spawn is allowed

Ports:
- `clk_i`  in  1  pixel clock
- `rst_i`  in  1  synchronous, active-high reset
- `next_frame_i`  in  1  one-cycle pulse at end of frame; all state updates happen here
- `spawn_i`  in  1  spawn request, sampled only when `next_frame_i`=1
- `rand_i`  in  8  random byte, sampled with `spawn_i`
- `speed_i`  in  4  pixels per frame scroll, sampled on `next_frame_i`
- `pixel_x_i`  in  10  current raster x
- `pixel_y_i`  in  10  current raster y
- `pixel_o`  out  1  1 when any active obstacle covers the raster pixel (registered)
- `active_o`  out  NumSlots  per-slot occupancy
- `spawned_o`  out  1  one-cycle pulse: spawn accepted
- `dropped_o`  out  1  one-cycle pulse: spawn request rejected
- `passed_o`  out  1  one-cycle pulse: at least one obstacle retired this frame (score tick)

## Operation
- Per slot, the block holds: `active`, `x[10:0]` (left edge, unsigned), and `kind[1:0]`: 0 = small cactus, 16x32; 1 = large cactus, 24x48; 2 = double cactus, 40x32; 3 = bird, 32x16.
- The y-bottom of each obstacle is `GroundY` for cacti.
- The y-bottom of a bird is `GroundY` − {0, 24, 48, 48}[h], where h = `rand_i[3:2]` latched at spawn.
- Frame update, on a cycle with `next_frame_i`=1, for every active slot, evaluated in parallel on pre-update values:
  - if `x < speed_i`: the slot goes inactive and `passed_o` pulses.
  - otherwise `x <= x − speed_i`.
- Spawn evaluation uses pre-update state in the same cycle. A request is accepted when all of the following hold:
  - `spawn_i`=1;
  - at least one slot was inactive before this update;
  - no active slot has `x > ScreenWidth − MinGap`.
- On acceptance, the lowest-index free slot is loaded with `x = ScreenWidth`, `kind = rand_i[1:0]` and h.
- A rejected request pulses `dropped_o` and leaves all slots unchanged.
- A slot retired in frame N is not reusable until frame N+1.
- With `speed_i`=0, nothing moves or retires; spawns are still evaluated.
- Pixel hit for a slot: `active && x <= pixel_x_i < x+w && bottom−hgt <= pixel_y_i < bottom`. Coordinates compare at 11 bits, so `x+w` past 639 simply clips.
- `pixel_o` is the OR over all slots of the per-slot hit.

## Timing
- `pixel_o` has 1-cycle latency from `pixel_x_i`/`pixel_y_i`.
- Slot state, `active_o` and the pulses update on the clock edge ending the `next_frame_i` cycle and are visible the following cycle.
- The pulses are high for exactly that one cycle.
- Reset, sampled on any edge including mid-frame: all slots inactive, `x`=0, `kind`=0, `pixel_o`=0, `active_o`=0, all pulses 0.
- `next_frame_i` asserted during reset is ignored.

## Configuration
- `OBSTACLE_BIRD_EN` defined:
  - kind 3 spawns birds as specified;
  - bird wing flap toggles the sprite height between 16 and 12 (top 4 rows cleared) every 8 frames, using a free-running 3-bit frame counter.
- `OBSTACLE_BIRD_EN` undefined:
  - a `rand_i[1:0]`=3 spawn becomes a small cactus (kind 0);
  - no flap counter is instantiated.

## Test plan
- Reset, then one frame with `spawn_i`=1, `rand_i`=8'h00, `speed_i`=4 -> `spawned_o` pulses, `active_o`=4'b0001, slot0 x=640.
- Frame 2 with `speed_i`=4 and `spawn_i`=1 -> slot0 x=636. The spawn is rejected because 640 > 640−160, so `dropped_o` pulses.
- Spawn with `rand_i`=8'h01, scan pixel (600,352) after slot x=596 -> `pixel_o`=1 one cycle later; (600,351) -> 0.
- Fill all 4 slots with 160-pixel spacing, then request another spawn -> `dropped_o`=1, `active_o`=4'b1111.
- Slot at x=3 with `speed_i`=4 -> `passed_o` pulses and the slot is freed. A spawn in that same frame is rejected if every other slot is full, and accepted the next frame.
- `rand_i`=8'h0F: with the macro, a bird at y 336..351 flaps after 8 frames; without the macro, a small cactus at y 368..399.
